// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-PC definitions: sequencer state encoding, PC width and default address map.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_MAX_ADDR   = 32'd260;

    function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] target);
        return {target[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline (master) and the fetch PC sequencer (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc;
    logic            inst_valid;
    logic            flush;
    logic            align_err;
    logic            wrap_event;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
        input  pc, inst_valid, flush, align_err, wrap_event
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
        output pc, inst_valid, flush, align_err, wrap_event
    );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC choice: branch > jump > stall > sequential, with target alignment
// and upper-bound wrap back to the reset address.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter logic [PC_W-1:0] MAX_ADDR   = DEFAULT_MAX_ADDR,
    parameter int unsigned     PC_INC     = 4
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            align_err,
    output logic            wrap
);
    logic [PC_W:0] seq_sum;
    logic [PC_W:0] cand;
    logic          bound_check;

    // Extra bit keeps the carry-out so an overflowing increment also counts as out of bound.
    assign seq_sum = {1'b0, pc} + (PC_W+1)'(PC_INC);

    always_comb begin
        redirect    = 1'b0;
        align_err   = 1'b0;
        bound_check = 1'b0;
        cand        = {1'b0, pc};
        if (branch_taken) begin
            redirect    = 1'b1;
            align_err   = |branch_target[1:0];
            bound_check = 1'b1;
            cand        = {1'b0, align_target(branch_target)};
        end else if (jump) begin
            redirect    = 1'b1;
            align_err   = |jump_target[1:0];
            bound_check = 1'b1;
            cand        = {1'b0, align_target(jump_target)};
        end else if (!stall) begin
            bound_check = 1'b1;
            cand        = seq_sum;
        end
        wrap    = bound_check && (cand > {1'b0, MAX_ADDR});
        next_pc = wrap ? RESET_ADDR : cand[PC_W-1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter owner: post-reset hold cycle, run, and redirect flush sequencing.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR   = DEFAULT_RESET_ADDR,
    parameter logic [PC_W-1:0] MAX_ADDR     = DEFAULT_MAX_ADDR,
    parameter int unsigned     PC_INC       = 4,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            align_q, align_d;
    logic            wrap_q, wrap_d;

    logic [PC_W-1:0] sel_pc;
    logic            sel_redirect;
    logic            sel_align;
    logic            sel_wrap;

    pc_next_sel #(
        .RESET_ADDR (RESET_ADDR),
        .MAX_ADDR   (MAX_ADDR),
        .PC_INC     (PC_INC)
    ) u_next_sel (
        .pc            (pc_q),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .next_pc       (sel_pc),
        .redirect      (sel_redirect),
        .align_err     (sel_align),
        .wrap          (sel_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            pc_q    <= RESET_ADDR;
            cnt_q   <= 3'd0;
            align_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            align_q <= align_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        align_d = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            ST_HOLD: state_d = ST_RUN;
            ST_RUN: begin
                pc_d    = sel_pc;
                align_d = sel_align;
                wrap_d  = sel_wrap;
                if (sel_redirect) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                pc_d    = sel_pc;
                align_d = sel_align;
                wrap_d  = sel_wrap;
                // A redirect while flushing restarts the bubble window.
                if (sel_redirect) begin
                    cnt_d = FLUSH_LOAD;
                end else if (!bus.stall) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_d == 3'd0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.inst_valid = (state_q == ST_RUN);
    assign bus.flush      = (state_q == ST_FLUSH);
    assign bus.align_err  = align_q;
    assign bus.wrap_event = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of two sequencers (1- and 3-cycle flush) against an
// address-level model of the fetch PC rules.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] MAX = 32'd260;
    localparam int unsigned INC = 4;
    localparam int          FC [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        in_stall, in_br, in_jp;
    logic [31:0] in_bt, in_jt;

    pc_sequencer_if sif0 ();
    pc_sequencer_if sif1 ();

    assign sif0.stall = in_stall;
    assign sif0.branch_taken = in_br;
    assign sif0.branch_target = in_bt;
    assign sif0.jump = in_jp;
    assign sif0.jump_target = in_jt;
    assign sif1.stall = in_stall;
    assign sif1.branch_taken = in_br;
    assign sif1.branch_target = in_bt;
    assign sif1.jump = in_jp;
    assign sif1.jump_target = in_jt;

    pc_sequencer #(.RESET_ADDR(32'h0), .MAX_ADDR(MAX), .PC_INC(INC), .FLUSH_CYCLES(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif0.slave)
    );

    pc_sequencer #(.RESET_ADDR(32'h0), .MAX_ADDR(MAX), .PC_INC(INC), .FLUSH_CYCLES(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif1.slave)
    );

    always #5 clk = ~clk;

    // Reference model: address arithmetic plus "bubbles left" and "in hold" bookkeeping.
    logic [31:0] m_pc    [2];
    bit          m_hold  [2];
    int          m_left  [2];
    bit          m_align [2];
    bit          m_wrap  [2];

    logic [31:0] o_pc [2];
    logic        o_iv [2], o_fl [2], o_al [2], o_wr [2];

    assign o_pc[0] = sif0.pc;
    assign o_iv[0] = sif0.inst_valid;
    assign o_fl[0] = sif0.flush;
    assign o_al[0] = sif0.align_err;
    assign o_wr[0] = sif0.wrap_event;
    assign o_pc[1] = sif1.pc;
    assign o_iv[1] = sif1.inst_valid;
    assign o_fl[1] = sif1.flush;
    assign o_al[1] = sif1.align_err;
    assign o_wr[1] = sif1.wrap_event;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0;
            m_hold[i] = 1'b1;
            m_left[i] = 0;
            m_align[i] = 1'b0;
            m_wrap[i] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            m_align[i] = 1'b0;
            m_wrap[i] = 1'b0;
            if (m_hold[i]) begin
                m_hold[i] = 1'b0;
            end else if (in_br || in_jp) begin
                logic [31:0] t;
                t = in_br ? in_bt : in_jt;
                m_align[i] = (t % 4) != 0;
                t = t - (t % 4);
                m_wrap[i] = t > MAX;
                m_pc[i] = m_wrap[i] ? 32'h0 : t;
                m_left[i] = FC[i];
            end else if (!in_stall) begin
                longint unsigned n;
                n = longint'(m_pc[i]) + longint'(INC);
                m_wrap[i] = n > longint'(MAX);
                m_pc[i] = m_wrap[i] ? 32'h0 : 32'(n);
                if (m_left[i] > 0) m_left[i]--;
            end
        end
    endfunction

    task automatic compare_all(input string where);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s pc%0d", where, i), o_pc[i], m_pc[i]);
            check($sformatf("%s inst_valid%0d", where, i), 32'(o_iv[i]),
                  32'(!m_hold[i] && m_left[i] == 0));
            check($sformatf("%s flush%0d", where, i), 32'(o_fl[i]), 32'(m_left[i] > 0));
            check($sformatf("%s align_err%0d", where, i), 32'(o_al[i]), 32'(m_align[i]));
            check($sformatf("%s wrap_event%0d", where, i), 32'(o_wr[i]), 32'(m_wrap[i]));
        end
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] bt, input bit j,
                        input logic [31:0] jt, input string tag);
        in_stall = s;
        in_br = b;
        in_bt = bt;
        in_jp = j;
        in_jt = jt;
        @(posedge clk);
        #1;
        model_step();
        compare_all(tag);
        in_stall = 1'b0;
        in_br = 1'b0;
        in_jp = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all({tag, " release"});
    endtask

    function automatic logic [31:0] pick_target();
        if ($urandom_range(9) == 0) return $urandom;
        return 32'($urandom_range(320));
    endfunction

    initial begin
        in_stall = 1'b0;
        in_br = 1'b0;
        in_jp = 1'b0;
        in_bt = 32'h0;
        in_jt = 32'h0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        compare_all("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all("hold");
        check("hold inst_valid", 32'(sif0.inst_valid), 32'd0);
        idle("first run");
        check("pc after hold", sif0.pc, 32'h0);
        check("inst_valid after hold", 32'(sif0.inst_valid), 32'd1);

        for (int k = 1; k <= 66; k++) begin
            idle("free run");
            if (k == 65) check("top of range", sif0.pc, 32'd260);
        end
        check("wrap pc", sif0.pc, 32'h0);
        check("wrap pulse", 32'(sif0.wrap_event), 32'd1);
        idle("after wrap");
        check("wrap pulse ends", 32'(sif0.wrap_event), 32'd0);

        for (int g = 0; g < 100 && m_pc[0] != 32'd16; g++) idle("to 16");
        step(1'b0, 1'b1, 32'd100, 1'b1, 32'd200, "branch+jump");
        check("branch beats jump", sif0.pc, 32'd100);
        check("flush after redirect", 32'(sif0.flush), 32'd1);
        idle("flush end");
        check("flush one cycle", 32'(sif0.flush), 32'd0);

        for (int g = 0; g < 200 && m_pc[0] != 32'd40; g++) idle("to 40");
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "stall");
            check("stall holds pc", sif0.pc, 32'd40);
            check("stall inst_valid", 32'(sif0.inst_valid), 32'd1);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'd80, "stall+jump");
        check("jump under stall", sif0.pc, 32'd80);

        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h43, "misaligned jump");
        check("aligned target", sif0.pc, 32'h40);
        check("align pulse", 32'(sif0.align_err), 32'd1);
        idle("after misaligned");
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'd300, "jump out of bound");
        check("target wrap pc", sif0.pc, 32'h0);
        check("target wrap pulse", 32'(sif0.wrap_event), 32'd1);

        repeat (4) idle("settle");
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, "jump before reset");
        idle("flush cycle 2");
        check("long flush active", 32'(sif1.flush), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset mid flush pc", sif1.pc, 32'h0);
        check("reset mid flush flush", 32'(sif1.flush), 32'd0);
        compare_all("reset mid flush");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all("reset mid flush release");

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(99) < 2) begin
                async_reset("random reset");
            end else begin
                step($urandom_range(99) < 30, $urandom_range(99) < 8, pick_target(),
                     $urandom_range(99) < 8, pick_target(), "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
